// File: rtl/line_tap_buffer_param.sv
// Multi-line tap shift register with runtime line length,
// frame-start re-priming, per-tap valid flags and column tracking.
module line_tap_buffer_param #(
  parameter int DW       = 32,
  parameter int MAX_LINE = 800,
  parameter int TAPS     = 4,
  parameter int LW       = 10
) (
  input  logic                 clock,
  input  logic                 aclr,
  input  logic                 clken,
  input  logic                 sof,
  input  logic [LW-1:0]        line_len,
  input  logic [DW-1:0]        shiftin,
  output logic [TAPS*DW-1:0]   taps,
  output logic [TAPS-1:0]      tap_valid,
  output logic [LW-1:0]        col,
  output logic                 eol,
  output logic                 out_en
);

  localparam int WW = TAPS * DW;
  localparam int CW = $clog2(TAPS + 1);
  localparam int AW = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
  localparam logic [LW-1:0] MAXL  = LW'(MAX_LINE);
  localparam logic [CW-1:0] TAPSC = CW'(TAPS);

  logic [WW-1:0]   mem [MAX_LINE];

  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   wp_q, wp_d;
  logic [LW-1:0]   col_q, col_d;
  logic [CW-1:0]   lc_q, lc_d;
  logic [TAPS-1:0] tv_q, tv_d;
  logic [WW-1:0]   taps_q, taps_d;
  logic            eol_q, eol_d;
  logic            oen_q, oen_d;

  logic [LW-1:0]   len_clamp;
  logic [LW-1:0]   len_eff;
  logic [LW-1:0]   wp_eff;
  logic [CW-1:0]   lc_base;
  logic            last;
  logic [WW-1:0]   rd_word;
  logic [WW-1:0]   wr_word;

  assign len_clamp = (line_len == '0 || line_len > MAXL)
                   ? MAXL : line_len;

  // A frame start re-primes this very sample as column 0
  assign len_eff = sof ? len_clamp : len_q;
  assign wp_eff  = sof ? '0 : wp_q;
  assign lc_base = sof ? '0 : lc_q;
  assign last    = (wp_eff == len_eff - 1'b1);
  assign rd_word = mem[wp_eff[AW-1:0]];

  generate
    if (TAPS == 1) begin : g_one
      assign wr_word = shiftin;
    end else begin : g_many
      assign wr_word = {rd_word[WW-DW-1:0], shiftin};
    end
  endgenerate

  always_comb begin
    len_d  = len_q;
    wp_d   = wp_q;
    col_d  = col_q;
    lc_d   = lc_q;
    tv_d   = tv_q;
    taps_d = taps_q;
    eol_d  = 1'b0;
    oen_d  = 1'b0;
    if (clken) begin
      len_d  = len_eff;
      wp_d   = last ? '0 : wp_eff + 1'b1;
      col_d  = wp_eff;
      taps_d = rd_word;
      eol_d  = last;
      oen_d  = 1'b1;
      lc_d   = (last && lc_base != TAPSC)
             ? lc_base + 1'b1 : lc_base;
      // Valid tracks the line count seen before this sample
      for (int k = 0; k < TAPS; k++) begin
        tv_d[k] = (lc_base > CW'(k));
      end
    end
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      len_q  <= MAXL;
      wp_q   <= '0;
      col_q  <= '0;
      lc_q   <= '0;
      tv_q   <= '0;
      taps_q <= '0;
      eol_q  <= 1'b0;
      oen_q  <= 1'b0;
    end else begin
      len_q  <= len_d;
      wp_q   <= wp_d;
      col_q  <= col_d;
      lc_q   <= lc_d;
      tv_q   <= tv_d;
      taps_q <= taps_d;
      eol_q  <= eol_d;
      oen_q  <= oen_d;
    end
  end

  always_ff @(posedge clock) begin
    if (clken && !aclr) begin
      mem[wp_eff[AW-1:0]] <= wr_word;
    end
  end

  assign taps      = taps_q;
  assign tap_valid = tv_q;
  assign col       = col_q;
  assign eol       = eol_q;
  assign out_en    = oen_q;

endmodule
